alu_reservation_station: RTL and testbench

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

---
 rtl/alu_reservation_station_pkg.sv | 48 ++++
 rtl/alu_reservation_station_if.sv | 49 ++++
 rtl/alu_reservation_station_rs_priority_select.sv | 14 +
 rtl/alu_reservation_station.sv | 121 ++++++++++++
 tb/tb_alu_reservation_station.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared out-of-order types: ALU op encoding, station operand/entry records and the CDB capture rule.
package alu_reservation_station_pkg;

  localparam int XLEN_MAX = 64;
  localparam int TAG_MAX  = 8;
  localparam int OP_W     = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_t;

  // Fields are sized for the widest supported station; narrower instances zero-extend.
  typedef struct packed {
    logic [XLEN_MAX-1:0] val;
    logic [TAG_MAX-1:0]  tag;
    logic                rdy;
  } rs_operand_t;

  typedef struct packed {
    logic               busy;
    alu_op_t            op;
    logic               sign;
    logic [TAG_MAX-1:0] dest_tag;
    rs_operand_t        a;
    rs_operand_t        b;
  } rs_entry_t;

  function automatic rs_operand_t rs_capture(input rs_operand_t opnd,
                                             input logic cdb_v,
                                             input logic [TAG_MAX-1:0] cdb_tag,
                                             input logic [XLEN_MAX-1:0] cdb_val);
    rs_operand_t r_res;
    r_res = opnd;
    if (cdb_v && !opnd.rdy && (opnd.tag == cdb_tag)) begin
      r_res.val = cdb_val;
      r_res.rdy = 1'b1;
    end
    return r_res;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB, flush and issue signals of the ALU reservation station.
interface alu_reservation_station_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
);
  import alu_reservation_station_pkg::*;

  logic                 dispatch_valid;
  logic [OP_W-1:0]      dispatch_op;
  logic                 dispatch_sign;
  logic [XLEN-1:0]      dispatch_a_value;
  logic [XLEN-1:0]      dispatch_b_value;
  logic [TAG_WIDTH-1:0] dispatch_a_tag;
  logic [TAG_WIDTH-1:0] dispatch_b_tag;
  logic                 dispatch_a_ready;
  logic                 dispatch_b_ready;
  logic [TAG_WIDTH-1:0] dispatch_dest_tag;
  logic                 dispatch_ready;

  logic                 cdb_valid;
  logic [TAG_WIDTH-1:0] cdb_tag;
  logic [XLEN-1:0]      cdb_value;
  logic                 flush;

  logic [XLEN-1:0]      a;
  logic [XLEN-1:0]      b;
  logic [OP_W-1:0]      op;
  logic                 sign;
  logic [TAG_WIDTH-1:0] dest_tag;
  logic                 ready_to_execute;
  logic                 accept;

  modport master (
    output dispatch_valid, dispatch_op, dispatch_sign,
           dispatch_a_value, dispatch_b_value, dispatch_a_tag, dispatch_b_tag,
           dispatch_a_ready, dispatch_b_ready, dispatch_dest_tag,
           cdb_valid, cdb_tag, cdb_value, flush, accept,
    input  dispatch_ready, a, b, op, sign, dest_tag, ready_to_execute
  );

  modport slave (
    input  dispatch_valid, dispatch_op, dispatch_sign,
           dispatch_a_value, dispatch_b_value, dispatch_a_tag, dispatch_b_tag,
           dispatch_a_ready, dispatch_b_ready, dispatch_dest_tag,
           cdb_valid, cdb_tag, cdb_value, flush, accept,
    output dispatch_ready, a, b, op, sign, dest_tag, ready_to_execute
  );

endinterface

// File: rtl/alu_reservation_station_rs_priority_select.sv
// Lowest-index one-hot grant from a request vector; shared by free-slot and issue selection.
module rs_priority_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_valid
);

  // Two's-complement trick isolates the least significant set bit.
  assign o_grant = i_req & (~i_req + N'(1));
  assign o_valid = |i_req;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive, issues lowest ready entry.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int N_ENTRIES = 4,
  parameter int TAG_WIDTH = 5
) (
  input logic                      clk,
  input logic                      reset,
  alu_reservation_station_if.slave io_rs
);

  rs_entry_t r_ent [N_ENTRIES];

  logic [N_ENTRIES-1:0] w_free_req;
  logic [N_ENTRIES-1:0] w_elig;
  logic [N_ENTRIES-1:0] w_free_oh;
  logic [N_ENTRIES-1:0] w_iss_oh;
  logic                 w_free_any;
  logic                 w_iss_any;
  logic                 w_do_disp;
  logic                 w_do_iss;
  logic [TAG_MAX-1:0]   w_cdb_tag;
  logic [XLEN_MAX-1:0]  w_cdb_val;
  rs_entry_t            w_new;
  logic [XLEN_MAX-1:0]  w_sel_a;
  logic [XLEN_MAX-1:0]  w_sel_b;
  alu_op_t              w_sel_op;
  logic                 w_sel_sign;
  logic [TAG_MAX-1:0]   w_sel_tag;

  // Both requests come only from registered state, so a slot freed by issue waits a cycle.
  always_comb begin
    w_free_req = '0;
    w_elig     = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      w_free_req[i] = !r_ent[i].busy;
      w_elig[i]     = r_ent[i].busy && r_ent[i].a.rdy && r_ent[i].b.rdy;
    end
  end

  rs_priority_select #(.N(N_ENTRIES)) u_free_sel (
    .i_req   (w_free_req),
    .o_grant (w_free_oh),
    .o_valid (w_free_any)
  );

  rs_priority_select #(.N(N_ENTRIES)) u_issue_sel (
    .i_req   (w_elig),
    .o_grant (w_iss_oh),
    .o_valid (w_iss_any)
  );

  assign w_cdb_tag = TAG_MAX'(io_rs.cdb_tag);
  assign w_cdb_val = XLEN_MAX'(io_rs.cdb_value);
  assign w_do_disp = io_rs.dispatch_valid && w_free_any && !io_rs.flush;
  assign w_do_iss  = w_iss_any && io_rs.accept;

  always_comb begin
    w_new          = '0;
    w_new.busy     = 1'b1;
    w_new.op       = alu_op_t'(io_rs.dispatch_op);
    w_new.sign     = io_rs.dispatch_sign;
    w_new.dest_tag = TAG_MAX'(io_rs.dispatch_dest_tag);
    w_new.a.val    = XLEN_MAX'(io_rs.dispatch_a_value);
    w_new.a.tag    = TAG_MAX'(io_rs.dispatch_a_tag);
    w_new.a.rdy    = io_rs.dispatch_a_ready;
    w_new.b.val    = XLEN_MAX'(io_rs.dispatch_b_value);
    w_new.b.tag    = TAG_MAX'(io_rs.dispatch_b_tag);
    w_new.b.rdy    = io_rs.dispatch_b_ready;
    // Same-cycle bypass so a producer broadcasting now is not missed.
    w_new.a        = rs_capture(w_new.a, io_rs.cdb_valid, w_cdb_tag, w_cdb_val);
    w_new.b        = rs_capture(w_new.b, io_rs.cdb_valid, w_cdb_tag, w_cdb_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) r_ent[i].busy <= 1'b0;
    end else if (io_rs.flush) begin
      for (int i = 0; i < N_ENTRIES; i++) r_ent[i].busy <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (w_do_disp && w_free_oh[i]) begin
          r_ent[i] <= w_new;
        end else if (r_ent[i].busy) begin
          r_ent[i].a <= rs_capture(r_ent[i].a, io_rs.cdb_valid, w_cdb_tag, w_cdb_val);
          r_ent[i].b <= rs_capture(r_ent[i].b, io_rs.cdb_valid, w_cdb_tag, w_cdb_val);
          if (w_do_iss && w_iss_oh[i]) r_ent[i].busy <= 1'b0;
        end
      end
    end
  end

  // One-hot AND-OR mux; yields all zeros when nothing is eligible.
  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_op   = ALU_ADD;
    w_sel_sign = 1'b0;
    w_sel_tag  = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (w_iss_oh[i]) begin
        w_sel_a    = r_ent[i].a.val;
        w_sel_b    = r_ent[i].b.val;
        w_sel_op   = r_ent[i].op;
        w_sel_sign = r_ent[i].sign;
        w_sel_tag  = r_ent[i].dest_tag;
      end
    end
  end

  assign io_rs.dispatch_ready   = w_free_any;
  assign io_rs.ready_to_execute = w_iss_any;
  assign io_rs.a                = XLEN'(w_sel_a);
  assign io_rs.b                = XLEN'(w_sel_b);
  assign io_rs.op               = w_sel_op;
  assign io_rs.sign             = w_sel_sign;
  assign io_rs.dest_tag         = TAG_WIDTH'(w_sel_tag);

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed scenarios plus randomized traffic checked against an entry-list reference model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int XL = 32;
  localparam int N  = 4;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_reservation_station_if #(.XLEN(XL), .TAG_WIDTH(TW)) bus ();

  alu_reservation_station #(.XLEN(XL), .N_ENTRIES(N), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .io_rs (bus)
  );

  // Reference model: a plain list of slots.
  bit          m_busy [N];
  bit [2:0]    m_op   [N];
  bit          m_sign [N];
  bit [TW-1:0] m_dest [N];
  bit [XL-1:0] m_av   [N];
  bit [XL-1:0] m_bv   [N];
  bit [TW-1:0] m_at   [N];
  bit [TW-1:0] m_bt   [N];
  bit          m_ar   [N];
  bit          m_br   [N];

  function automatic int m_sel();
    for (int i = 0; i < N; i++) if (m_busy[i] && m_ar[i] && m_br[i]) return i;
    return -1;
  endfunction

  function automatic bit m_has_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    bus.dispatch_valid = 0; bus.dispatch_op = 0; bus.dispatch_sign = 0;
    bus.dispatch_a_value = 0; bus.dispatch_b_value = 0;
    bus.dispatch_a_tag = 0; bus.dispatch_b_tag = 0;
    bus.dispatch_a_ready = 0; bus.dispatch_b_ready = 0; bus.dispatch_dest_tag = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0;
    bus.flush = 0; bus.accept = 0;
  endtask

  task automatic set_disp(input logic [2:0] op, input logic sg,
                          input logic [XL-1:0] av, input logic ar, input logic [TW-1:0] at,
                          input logic [XL-1:0] bv, input logic br, input logic [TW-1:0] bt,
                          input logic [TW-1:0] dst);
    bus.dispatch_valid = 1; bus.dispatch_op = op; bus.dispatch_sign = sg;
    bus.dispatch_a_value = av; bus.dispatch_a_ready = ar; bus.dispatch_a_tag = at;
    bus.dispatch_b_value = bv; bus.dispatch_b_ready = br; bus.dispatch_b_tag = bt;
    bus.dispatch_dest_tag = dst;
  endtask

  // Advance the model with the current inputs, then clock the DUT and settle.
  task automatic step();
    int iss = m_sel();
    int fr  = -1;
    for (int i = 0; i < N; i++) if (fr < 0 && !m_busy[i]) fr = i;
    if (reset || bus.flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 0;
    end else begin
      if (bus.cdb_valid) begin
        for (int i = 0; i < N; i++) begin
          if (m_busy[i] && !m_ar[i] && m_at[i] == bus.cdb_tag) begin m_av[i] = bus.cdb_value; m_ar[i] = 1; end
          if (m_busy[i] && !m_br[i] && m_bt[i] == bus.cdb_tag) begin m_bv[i] = bus.cdb_value; m_br[i] = 1; end
        end
      end
      if (iss >= 0 && bus.accept) m_busy[iss] = 0;
      if (bus.dispatch_valid && fr >= 0) begin
        m_busy[fr] = 1; m_op[fr] = bus.dispatch_op; m_sign[fr] = bus.dispatch_sign;
        m_dest[fr] = bus.dispatch_dest_tag;
        m_av[fr] = bus.dispatch_a_value; m_ar[fr] = bus.dispatch_a_ready; m_at[fr] = bus.dispatch_a_tag;
        m_bv[fr] = bus.dispatch_b_value; m_br[fr] = bus.dispatch_b_ready; m_bt[fr] = bus.dispatch_b_tag;
        if (bus.cdb_valid && !m_ar[fr] && m_at[fr] == bus.cdb_tag) begin m_av[fr] = bus.cdb_value; m_ar[fr] = 1; end
        if (bus.cdb_valid && !m_br[fr] && m_bt[fr] == bus.cdb_tag) begin m_bv[fr] = bus.cdb_value; m_br[fr] = 1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    set_disp(ALU_ADD, 0, 32'h1, 1, 0, 32'h2, 1, 0, 5'd1);
    bus.flush = 1; bus.accept = 1;
    step(); step();
    checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_dispatch_ready got=%0b exp=1", bus.dispatch_ready); end
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL reset_rte got=%0b exp=0", bus.ready_to_execute); end
    checks++; if (bus.a !== '0 || bus.b !== '0) begin errors++; $display("FAIL reset_ab got=%0h/%0h exp=0/0", bus.a, bus.b); end
    checks++; if (bus.op !== 3'd0 || bus.sign !== 1'b0 || bus.dest_tag !== '0) begin errors++; $display("FAIL reset_op_sign_tag got=%0h/%0b/%0h exp=0/0/0", bus.op, bus.sign, bus.dest_tag); end
    reset = 0;
    idle();
  endtask

  task automatic test_basic_issue();
    set_disp(ALU_ADD, 0, 32'd5, 1, 0, 32'd7, 1, 0, 5'd3);
    bus.accept = 1;
    step();
    bus.dispatch_valid = 0;
    checks++; if (bus.ready_to_execute !== 1'b1) begin errors++; $display("FAIL basic_rte got=%0b exp=1", bus.ready_to_execute); end
    checks++; if (bus.a !== 32'd5 || bus.b !== 32'd7) begin errors++; $display("FAIL basic_ab got=%0h/%0h exp=5/7", bus.a, bus.b); end
    checks++; if (bus.dest_tag !== 5'd3 || bus.op !== ALU_ADD) begin errors++; $display("FAIL basic_tag_op got=%0h/%0h exp=3/0", bus.dest_tag, bus.op); end
    step();
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL basic_drained got=%0b exp=0", bus.ready_to_execute); end
    idle();
  endtask

  task automatic test_cdb_wakeup();
    set_disp(ALU_SUB, 1, 32'd1, 1, 0, 32'd0, 0, 5'd9, 5'd2);
    step();
    bus.dispatch_valid = 0;
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL wake_waiting got=%0b exp=0", bus.ready_to_execute); end
    bus.cdb_valid = 1; bus.cdb_tag = 5'd8; bus.cdb_value = 32'h55;
    step();
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL wake_wrong_tag got=%0b exp=0", bus.ready_to_execute); end
    bus.cdb_tag = 5'd9; bus.cdb_value = 32'h10;
    step();
    bus.cdb_valid = 0;
    checks++; if (bus.ready_to_execute !== 1'b1) begin errors++; $display("FAIL wake_rte got=%0b exp=1", bus.ready_to_execute); end
    checks++; if (bus.b !== 32'h10 || bus.a !== 32'd1) begin errors++; $display("FAIL wake_ab got=%0h/%0h exp=1/10", bus.a, bus.b); end
    checks++; if (bus.op !== ALU_SUB || bus.sign !== 1'b1 || bus.dest_tag !== 5'd2) begin errors++; $display("FAIL wake_fields got=%0h/%0b/%0h exp=1/1/2", bus.op, bus.sign, bus.dest_tag); end
    bus.accept = 1;
    step();
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL wake_drained got=%0b exp=0", bus.ready_to_execute); end
    idle();
  endtask

  task automatic test_bypass();
    set_disp(ALU_XOR, 0, 32'h22, 1, 0, 32'h0, 0, 5'd4, 5'd6);
    bus.cdb_valid = 1; bus.cdb_tag = 5'd4; bus.cdb_value = 32'hAB;
    step();
    idle();
    checks++; if (bus.ready_to_execute !== 1'b1) begin errors++; $display("FAIL bypass_rte got=%0b exp=1", bus.ready_to_execute); end
    checks++; if (bus.b !== 32'hAB || bus.a !== 32'h22) begin errors++; $display("FAIL bypass_ab got=%0h/%0h exp=22/ab", bus.a, bus.b); end
    bus.accept = 1;
    step();
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL bypass_drained got=%0b exp=0", bus.ready_to_execute); end
    idle();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      set_disp(ALU_OR, 0, XL'(k + 1), 1, 0, XL'(k + 100), 1, 0, TW'(10 + k));
      step();
      checks++; if (bus.dispatch_ready !== (k < 3)) begin errors++; $display("FAIL full_ready_%0d got=%0b exp=%0b", k, bus.dispatch_ready, (k < 3)); end
    end
    set_disp(ALU_AND, 0, 32'hF, 1, 0, 32'hF, 1, 0, 5'd7);
    step();
    bus.dispatch_valid = 0;
    checks++; if (bus.dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_fifth_ready got=%0b exp=0", bus.dispatch_ready); end
    checks++; if (bus.dest_tag !== 5'd10) begin errors++; $display("FAIL full_first_sel got=%0d exp=10", bus.dest_tag); end
    bus.accept = 1;
    step();
    checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL full_freed_ready got=%0b exp=1", bus.dispatch_ready); end
    checks++; if (bus.dest_tag !== 5'd11) begin errors++; $display("FAIL full_sel_1 got=%0d exp=11", bus.dest_tag); end
    for (int k = 2; k < 4; k++) begin
      step();
      checks++; if (bus.dest_tag !== TW'(10 + k)) begin errors++; $display("FAIL full_sel_%0d got=%0d exp=%0d", k, bus.dest_tag, 10 + k); end
    end
    step();
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL full_fifth_dropped got=%0b exp=0", bus.ready_to_execute); end
    idle();
  endtask

  task automatic test_priority();
    set_disp(ALU_ADD, 0, 32'h0, 0, 5'd20, 32'h0, 1, 0, 5'd1);
    step();
    set_disp(ALU_SLT, 1, 32'h11, 1, 0, 32'h1, 1, 0, 5'd11);
    step();
    set_disp(ALU_SLL, 0, 32'h12, 1, 0, 32'h2, 1, 0, 5'd12);
    step();
    bus.dispatch_valid = 0;
    checks++; if (bus.dest_tag !== 5'd11 || bus.op !== ALU_SLT) begin errors++; $display("FAIL prio_first got=%0d/%0h exp=11/5", bus.dest_tag, bus.op); end
    bus.accept = 1;
    step();
    checks++; if (bus.dest_tag !== 5'd12 || bus.a !== 32'h12) begin errors++; $display("FAIL prio_second got=%0d/%0h exp=12/12", bus.dest_tag, bus.a); end
    step();
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL prio_waiting_left got=%0b exp=0", bus.ready_to_execute); end
    idle();
  endtask

  task automatic test_flush();
    // Entry 0 is still waiting on tag 20 from the previous scenario.
    for (int k = 0; k < 2; k++) begin
      set_disp(ALU_SRL, 0, 32'h0, 0, 5'd21, 32'h3, 1, 0, TW'(16 + k));
      step();
    end
    set_disp(ALU_ADD, 0, 32'h1, 1, 0, 32'h1, 1, 0, 5'd5);
    bus.flush = 1; bus.accept = 1;
    bus.cdb_valid = 1; bus.cdb_tag = 5'd20; bus.cdb_value = 32'h99;
    step();
    idle();
    checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0b exp=1", bus.dispatch_ready); end
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL flush_rte got=%0b exp=0", bus.ready_to_execute); end
    bus.cdb_valid = 1; bus.cdb_tag = 5'd21; bus.cdb_value = 32'h77;
    step();
    idle();
    checks++; if (bus.ready_to_execute !== 1'b0) begin errors++; $display("FAIL flush_no_wake got=%0b exp=0", bus.ready_to_execute); end
    for (int k = 0; k < 4; k++) begin
      set_disp(ALU_ADD, 0, 32'h0, 0, 5'd30, 32'h0, 0, 5'd30, TW'(k));
      step();
      checks++; if (bus.dispatch_ready !== (k < 3)) begin errors++; $display("FAIL flush_refill_%0d got=%0b exp=%0b", k, bus.dispatch_ready, (k < 3)); end
    end
    idle();
    bus.flush = 1;
    step();
    idle();
    checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL flush_final got=%0b exp=1", bus.dispatch_ready); end
  endtask

  task automatic test_random();
    int          sel;
    logic [XL-1:0] ea, eb;
    logic [2:0]  eop;
    logic        esg;
    logic [TW-1:0] etag;
    for (int c = 0; c < 500; c++) begin
      bus.dispatch_valid    = ($urandom_range(0, 99) < 60);
      bus.dispatch_op       = 3'($urandom_range(0, 7));
      bus.dispatch_sign     = 1'($urandom_range(0, 1));
      bus.dispatch_a_value  = $urandom;
      bus.dispatch_b_value  = $urandom;
      bus.dispatch_a_ready  = 1'($urandom_range(0, 1));
      bus.dispatch_b_ready  = 1'($urandom_range(0, 1));
      bus.dispatch_a_tag    = TW'($urandom_range(0, 7));
      bus.dispatch_b_tag    = TW'($urandom_range(0, 7));
      bus.dispatch_dest_tag = TW'($urandom_range(0, 31));
      bus.cdb_valid         = ($urandom_range(0, 99) < 40);
      bus.cdb_tag           = TW'($urandom_range(0, 7));
      bus.cdb_value         = $urandom;
      bus.accept            = ($urandom_range(0, 99) < 50);
      bus.flush             = ($urandom_range(0, 99) < 3);
      reset                 = ($urandom_range(0, 199) < 1);
      step();
      sel = m_sel();
      if (sel >= 0) begin
        ea = m_av[sel]; eb = m_bv[sel]; eop = m_op[sel]; esg = m_sign[sel]; etag = m_dest[sel];
      end else begin
        ea = '0; eb = '0; eop = '0; esg = 1'b0; etag = '0;
      end
      checks++; if (bus.dispatch_ready !== m_has_free()) begin errors++; $display("FAIL rnd_dispatch_ready cyc=%0d got=%0b exp=%0b", c, bus.dispatch_ready, m_has_free()); end
      checks++; if (bus.ready_to_execute !== (sel >= 0)) begin errors++; $display("FAIL rnd_rte cyc=%0d got=%0b exp=%0b", c, bus.ready_to_execute, (sel >= 0)); end
      checks++; if (bus.a !== ea) begin errors++; $display("FAIL rnd_a cyc=%0d got=%0h exp=%0h", c, bus.a, ea); end
      checks++; if (bus.b !== eb) begin errors++; $display("FAIL rnd_b cyc=%0d got=%0h exp=%0h", c, bus.b, eb); end
      checks++; if (bus.op !== eop || bus.sign !== esg) begin errors++; $display("FAIL rnd_op_sign cyc=%0d got=%0h/%0b exp=%0h/%0b", c, bus.op, bus.sign, eop, esg); end
      checks++; if (bus.dest_tag !== etag) begin errors++; $display("FAIL rnd_dest_tag cyc=%0d got=%0h exp=%0h", c, bus.dest_tag, etag); end
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_bypass();
    test_full();
    test_priority();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
